// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RISC-V M-extension multiply/divide unit
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module mdu_iter #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  // Operand conditioning at the accept edge
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, is_special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    a_signed = (in_op == 3'b001) || (in_op == 3'b010) ||
               (in_op == 3'b100) || (in_op == 3'b110);
    b_signed = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
    a_neg    = a_signed & in_a[XLEN-1];
    b_neg    = b_signed & in_b[XLEN-1];
    mag_a    = a_neg ? -in_a : in_a;
    mag_b    = b_neg ? -in_b : in_b;
    div_zero = in_op[2] && (in_b == '0);
    div_ovf  = in_op[2] && !in_op[0] && (in_b == '1) &&
               (in_a == {1'b1, {(XLEN-1){1'b0}}});
    is_special = div_zero || div_ovf;
    if (div_zero) begin
      special_val = in_op[1] ? in_a : '1;
    end else begin
      special_val = in_op[1] ? '0 : in_a;
    end
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN:0]   mul_tmp;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN:0]   div_shift;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_tmp   = acc_q[0] ? {mul_sum, acc_q[XLEN-1:0]} : {1'b0, acc_q};
    mul_next  = mul_tmp[2*XLEN:1];
    div_shift = {acc_q, 1'b0};
    div_trial = {1'b0, div_shift[2*XLEN:XLEN]} - {2'b00, opnd_q};
    // A set top bit means the trial subtraction borrowed; keep the shifted value.
    if (div_trial[XLEN+1]) begin
      div_next = div_shift[2*XLEN-1:0];
    end else begin
      div_next = {div_trial[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d     = in_op;
          sign_a_d = a_neg;
          sign_b_d = b_neg;
          cnt_d    = '0;
          if (is_special) begin
            state_d   = S_DONE;
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, special_val};
          end else begin
            state_d   = S_BUSY;
            special_d = 1'b0;
            opnd_d    = in_op[2] ? mag_b : mag_a;
            acc_d     = {{XLEN{1'b0}}, (in_op[2] ? mag_a : mag_b)};
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
    end
  end

  // Sign fixup from registered magnitudes, then result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_result;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      calc_result = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q[1:0] == 2'b00) begin
      calc_result = prod_fix[XLEN-1:0];
    end else begin
      calc_result = prod_fix[2*XLEN-1:XLEN];
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = (state_q == S_DONE) ?
                      (special_q ? acc_q[XLEN-1:0] : calc_result) : '0;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit; the sequential companion to the combinational ALU in the execute stage.
- Implements the full RISC-V M-extension set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at width XLEN.
- Uses radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshakes on both input and output; flush input for pipeline kills.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and even; 32 and 64 supported.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  abort any operation in flight; the unit returns to IDLE on the next edge.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- in_op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  input  XLEN  rs1 operand (multiplicand or dividend).
- in_b  input  XLEN  rs2 operand (multiplier or divisor).
- out_valid  output  1  result valid; held until it is accepted.
- out_ready  input  1  consumer accepts the result.
- out_result  output  XLEN  result; stable while out_valid=1.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- States: IDLE, BUSY, DONE. Reset value: IDLE, out_valid=0, in_ready=1, busy=0, out_result=0, counter=0.
- Accept when in_valid & in_ready are both high at an edge. At that edge, latch op, operand signs, and operand magnitudes:
  - Signed operand: a negative operand is two's-complement negated; the signed mask is a for MULH/MULHSU/DIV/REM, and b for MULH/DIV/REM.
  - Accepting clears the counter.
- Special cases, decided at accept (go directly to DONE; out_valid high on the cycle after acceptance, latency 1):
  - Divisor = 0: DIV/DIVU give all ones; REM/REMU give in_a.
  - Signed overflow (DIV/REM with a = 100…0 and b = all ones): DIV gives in_a; REM gives 0.
- BUSY, multiply: per cycle, if multiplier LSB is 1, add the multiplicand into the upper half of a 2·XLEN accumulator (with carry bit); then shift right 1.
- BUSY, divide: per cycle, shift the remainder:dividend pair left 1, trial-subtract the divisor from the upper half; if no borrow, keep the difference and set quotient bit = 1.
- The counter increments each BUSY cycle. After exactly XLEN iterations, go to DONE; out_valid rises XLEN cycles after the accept edge.
- Sign fixup is applied combinationally from registered magnitudes and sign flags:
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder takes the dividend's sign.
- Result selection: MUL = low XLEN of the product; MULH/MULHSU/MULHU = high XLEN of the product.
- DONE: out_valid=1 and out_result held. At an edge with out_ready=1, go to IDLE; in_ready rises the next cycle. There is no accept in the same cycle as output handoff (no bypass).
- Backpressure: DONE is held indefinitely; out_result must not change.
- flush:
  - From any state, go to IDLE next edge and drop out_valid; a result in DONE is discarded.
  - flush has priority over out_ready and over acceptance.
  - in_valid in the same cycle as flush is not accepted.
- rst mid-operation: identical to flush plus all registers cleared; rst has priority over flush.
- Operand and op inputs are ignored outside the accept edge; changing them during BUSY has no effect.
- All arithmetic is modular at its stated width; no exceptions are raised.

Test Plan:
- XLEN=32, MUL a=7, b=0xFFFFFFFD (−3), out_ready=1.
  - Required: out_result=0xFFFFFFEB.
  - Required: out_valid exactly 32 cycles after accept.
  - Required: in_ready low for 33 cycles.
- XLEN=32, MULH a=b=0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- XLEN=32 divide results:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF/16 → 0x0FFFFFFF.
  - REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Each with out_valid 1 cycle after accept.
- Control scenarios:
  - Hold out_ready=0 for 10 cycles in DONE: out_valid and out_result stay stable; release → IDLE next edge.
  - Assert flush at BUSY cycle 5: IDLE next edge, no out_valid.
  - A new MUL 3×4 → 12 completes normally after the flush.
- Width and reset scenarios:
  - XLEN=64, MUL 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → MUL 1, MULHU 0xFFFFFFFFFFFFFFFE; latency 64.
  - rst at BUSY cycle 20 → all outputs at reset values next edge.
